// File: rtl/arb_pkg.sv
// Shared types and helpers for the four-requester round-robin arbiter.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef logic [IDX_W-1:0] arb_idx_t;

  function automatic logic [NUM_REQ-1:0] idx_onehot(input arb_idx_t idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first requester after last_idx, searching upward mod 4.
module rr_pick
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  arb_idx_t           last_idx,
  output logic               any_req,
  output arb_idx_t           win_idx
);

  arb_idx_t           start_s;
  arb_idx_t           pos_s;
  logic [NUM_REQ-1:0] rot_s;
  arb_idx_t           off_s;

  // Rotate the request vector so bit 0 is the slot right after last_idx.
  always_comb begin
    start_s = last_idx + 2'd1;
    pos_s   = 2'd0;
    rot_s   = 4'b0000;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos_s    = start_s + arb_idx_t'(k);
      rot_s[k] = req[pos_s];
    end
  end

  // Priority-encode the rotated vector; lowest offset wins.
  always_comb begin
    casez (rot_s)
      4'b???1: off_s = 2'd0;
      4'b??10: off_s = 2'd1;
      4'b?100: off_s = 2'd2;
      4'b1000: off_s = 2'd3;
      default: off_s = 2'd0;
    endcase
  end

  assign any_req = |req;
  assign win_idx = start_s + off_s;

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with bounded hold time, index output as x1/x0.
// Define ARB_LOCK_EN to add a `lock` input that suppresses timeout preemption.
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
`ifdef ARB_LOCK_EN
  input  logic               lock,
`endif
  output logic               x1,
  output logic               x0,
  output logic               grant_valid,
  output logic               grant_new
);

  localparam int             CNT_W     = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_t       state_r, next_state_s;
  logic [CNT_W-1:0] hold_cnt_r, next_hold_s;
  arb_idx_t         last_idx_r, next_last_s;
  arb_idx_t         next_idx_s;
  logic             next_valid_s;
  logic             next_new_s;

  logic             any_req_s;
  arb_idx_t         win_idx_s;
  logic             others_s;
  logic             cur_req_s;
  logic             timeout_s;

  rr_pick u_pick (
    .req      (req),
    .last_idx (last_idx_r),
    .any_req  (any_req_s),
    .win_idx  (win_idx_s)
  );

  // In GRANT, last_idx_r is always the index currently granted.
  assign others_s  = |(req & ~idx_onehot(last_idx_r));
  assign cur_req_s = req[last_idx_r];
`ifdef ARB_LOCK_EN
  assign timeout_s = (hold_cnt_r == HOLD_LAST) && !lock;
`else
  assign timeout_s = (hold_cnt_r == HOLD_LAST);
`endif

  // Next-state and next-output decode.
  always_comb begin
    next_state_s = state_r;
    next_hold_s  = hold_cnt_r;
    next_last_s  = last_idx_r;
    next_idx_s   = {x1, x0};
    next_valid_s = grant_valid;
    next_new_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          next_state_s = GRANT;
          next_idx_s   = win_idx_s;
          next_last_s  = win_idx_s;
          next_hold_s  = '0;
          next_valid_s = 1'b1;
          next_new_s   = 1'b1;
        end else begin
          next_valid_s = 1'b0;
        end
      end
      GRANT: begin
        if (!cur_req_s || (timeout_s && others_s)) begin
          if (others_s) begin
            next_idx_s   = win_idx_s;
            next_last_s  = win_idx_s;
            next_hold_s  = '0;
            next_valid_s = 1'b1;
            next_new_s   = 1'b1;
          end else begin
            next_state_s = IDLE;
            next_valid_s = 1'b0;
          end
        end else if (hold_cnt_r != HOLD_LAST) begin
          next_hold_s = hold_cnt_r + CNT_W'(1);
        end else begin
          next_hold_s = hold_cnt_r;
        end
      end
      default: begin
        next_state_s = IDLE;
        next_valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers; last_idx resets to 3 so the first search starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      hold_cnt_r  <= '0;
      last_idx_r  <= 2'd3;
      x1          <= 1'b0;
      x0          <= 1'b0;
      grant_valid <= 1'b0;
      grant_new   <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      hold_cnt_r  <= next_hold_s;
      last_idx_r  <= next_last_s;
      x1          <= next_idx_s[1];
      x0          <= next_idx_s[0];
      grant_valid <= next_valid_s;
      grant_new   <= next_new_s;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4 (MAX_HOLD=8); lock scenario runs when ARB_LOCK_EN is defined.
module tb_rr_arbiter_4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       lock;
  logic       x1, x0, grant_valid, grant_new;

  int total;
  int bad;

  rr_arbiter_4 #(.MAX_HOLD(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
`ifdef ARB_LOCK_EN
    .lock        (lock),
`endif
    .x1          (x1),
    .x0          (x0),
    .grant_valid (grant_valid),
    .grant_new   (grant_new)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    req   = 4'b0000;
    lock  = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    logic [3:0] obs;
    req   = 4'b0000;
    lock  = 1'b0;
    rst_n = 1'b0;
    #2;
    obs = {x1, x0, grant_valid, grant_new};
    total++;
    if (obs !== 4'b0000) begin
      bad++;
      $display("FAIL reset_state: got %b want 0000 ({x1,x0,valid,new})", obs);
    end
    step();
    rst_n = 1'b1;
    step();
    obs = {x1, x0, grant_valid, grant_new};
    total++;
    if (obs !== 4'b0000) begin
      bad++;
      $display("FAIL idle_no_req: got %b want 0000", obs);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] obs;
    logic [3:0] exp_tab [4];
    logic [3:0] req_tab [4];
    exp_tab = '{4'b0011, 4'b0111, 4'b1011, 4'b1111};
    req_tab = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};
    reset_dut();
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      step();
      obs = {x1, x0, grant_valid, grant_new};
      total++;
      if (obs !== exp_tab[i]) begin
        bad++;
        $display("FAIL rotation[%0d]: got %b want %b", i, obs, exp_tab[i]);
      end
      req = req_tab[i];
    end
    step();
    obs = {x1, x0, grant_valid, grant_new};
    total++;
    if (obs !== 4'b1100) begin
      bad++;
      $display("FAIL rotation_to_idle: got %b want 1100", obs);
    end
  endtask

  task automatic test_lone();
    logic [3:0] obs;
    logic [3:0] exp;
    reset_dut();
    req = 4'b0100;
    for (int i = 0; i < 20; i++) begin
      step();
      obs = {x1, x0, grant_valid, grant_new};
      exp = (i == 0) ? 4'b1011 : 4'b1010;
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL lone_hold[%0d]: got %b want %b", i, obs, exp);
      end
    end
    req = 4'b0000;
    step();
  endtask

  task automatic test_timeout();
    logic [3:0] obs;
    logic [1:0] exp_idx;
    logic       exp_new;
    reset_dut();
    req = 4'b1001;
    for (int i = 0; i < 20; i++) begin
      step();
      exp_idx = ((i / 8) % 2 == 0) ? 2'b00 : 2'b11;
      exp_new = (i % 8 == 0);
      obs = {x1, x0, grant_valid, grant_new};
      total++;
      if (obs !== {exp_idx, 1'b1, exp_new}) begin
        bad++;
        $display("FAIL timeout[%0d]: got %b want %b", i, obs, {exp_idx, 1'b1, exp_new});
      end
    end
    req = 4'b0000;
    step();
  endtask

  task automatic test_release_idle();
    logic [3:0] obs;
    reset_dut();
    req = 4'b0010;
    step();
    obs = {x1, x0, grant_valid, grant_new};
    total++;
    if (obs !== 4'b0111) begin
      bad++;
      $display("FAIL release_first_grant: got %b want 0111", obs);
    end
    step();
    step();
    req = 4'b0000;
    step();
    obs = {x1, x0, grant_valid, grant_new};
    total++;
    if (obs !== 4'b0100) begin
      bad++;
      $display("FAIL release_to_idle: got %b want 0100", obs);
    end
    step();
    obs = {x1, x0, grant_valid, grant_new};
    total++;
    if (obs !== 4'b0100) begin
      bad++;
      $display("FAIL idle_hold_index: got %b want 0100", obs);
    end
    req = 4'b0010;
    step();
    obs = {x1, x0, grant_valid, grant_new};
    total++;
    if (obs !== 4'b0111) begin
      bad++;
      $display("FAIL regrant_same: got %b want 0111", obs);
    end
    step();
    obs = {x1, x0, grant_valid, grant_new};
    total++;
    if (obs !== 4'b0110) begin
      bad++;
      $display("FAIL regrant_hold: got %b want 0110", obs);
    end
    req = 4'b0000;
    step();
  endtask

  task automatic test_async_reset();
    logic [3:0] obs;
    reset_dut();
    req = 4'b0100;
    step();
    step();
    obs = {x1, x0, grant_valid, grant_new};
    total++;
    if (obs !== 4'b1010) begin
      bad++;
      $display("FAIL pre_reset_grant: got %b want 1010", obs);
    end
    #3;
    rst_n = 1'b0;
    #1;
    obs = {x1, x0, grant_valid, grant_new};
    total++;
    if (obs !== 4'b0000) begin
      bad++;
      $display("FAIL async_reset: got %b want 0000", obs);
    end
    #1;
    rst_n = 1'b1;
    req   = 4'b1100;
    step();
    obs = {x1, x0, grant_valid, grant_new};
    total++;
    if (obs !== 4'b1011) begin
      bad++;
      $display("FAIL post_reset_grant: got %b want 1011", obs);
    end
    req = 4'b0000;
    step();
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    logic [3:0] obs;
    logic [3:0] exp;
    reset_dut();
    lock = 1'b1;
    req  = 4'b0011;
    for (int i = 0; i < 20; i++) begin
      step();
      obs = {x1, x0, grant_valid, grant_new};
      exp = (i == 0) ? 4'b0011 : 4'b0010;
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL lock_hold[%0d]: got %b want %b", i, obs, exp);
      end
    end
    lock = 1'b0;
    step();
    obs = {x1, x0, grant_valid, grant_new};
    total++;
    if (obs !== 4'b0111) begin
      bad++;
      $display("FAIL lock_release_rotate: got %b want 0111", obs);
    end
    req = 4'b0000;
    step();
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    req   = 4'b0000;
    lock  = 1'b0;
    test_reset();
    test_rotation();
    test_lone();
    test_timeout();
    test_release_idle();
    test_async_reset();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
- Four-requester round-robin arbiter that produces the 2-bit winner index as separate bits x1/x0.
- Sits directly upstream of the team's 2-to-4 decoder. The decoder turns x1/x0 into the one-hot grant / enable vector.
- Registered outputs, fair rotation, and a bounded hold time per grant so that no requester starves.

Parameters:
- MAX_HOLD, 8: maximum consecutive cycles one requester keeps the grant while another requester is waiting. Legal range 1..255.
- CNT_W, $clog2(MAX_HOLD+1): width of the hold counter. Derived; do not override.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- req, input, 4: request vector; req[i] high = requester i wants the grant. Synchronous to clk.
- x1, output, 1: MSB of the granted index; connects to the decoder's x1.
- x0, output, 1: LSB of the granted index; connects to the decoder's x0.
- grant_valid, output, 1: high while {x1,x0} names a live grant.
- grant_new, output, 1: one-cycle pulse on the first cycle of each new grant, including a back-to-back change of winner.

Behaviour:
- All state and outputs are registered. Reset is asynchronous and active-low: asserting rst_n clears everything immediately, independent of clk.
- Reset values:
  - x1=0, x0=0
  - grant_valid=0, grant_new=0
  - state=IDLE
  - hold_cnt=0
  - last_idx=3, so the first pick starts at index 0.
- Pick rule (combinational):
  - Search order is last_idx+1, +2, +3, +4, all mod 4.
  - The first index found with req set wins.
  - "others pending" = any req[j] set with j != current index.
- State IDLE:
  - If req==0: stay in IDLE. grant_valid=0; x1/x0 hold their previous value.
  - If any req is set: next edge loads the winner into {x1,x0}, sets grant_valid=1 and grant_new=1, sets last_idx=winner, clears hold_cnt, and moves to GRANT.
  - Latency: req rising at edge N → grant visible after edge N+1.
- State GRANT, evaluated every edge:
  - Release: req[cur]==0.
    - If others are pending: grant the next winner on the same edge. grant_valid stays 1, grant_new=1.
    - Otherwise: go to IDLE. grant_valid=0, grant_new=0.
  - Timeout: hold_cnt==MAX_HOLD-1 and others pending. Preempt and rotate to the next winner exactly as for a release with others pending.
  - Otherwise: keep the grant and increment hold_cnt, saturating at MAX_HOLD-1.
    - A lone requester keeps the grant indefinitely.
    - grant_new=0.
- MAX_HOLD=1: under contention the grant rotates every cycle and grant_new is high every cycle.
- Re-grant of the same index only happens through IDLE, i.e. the requester dropped req and raised it again. In that case grant_new pulses again.
- rst_n asserted mid-grant: grant_valid falls immediately (asynchronously). After reset is released, arbitration restarts from index 0.

Optional Feature:
- Macro: ARB_LOCK_EN.
- When defined:
  - Adds input port `lock` (1 bit).
  - While lock=1 in GRANT, timeout preemption is suppressed: hold_cnt saturates and the grant persists until req[cur] drops.
  - lock has no effect in IDLE.
- When undefined: no `lock` port exists, and behaviour is exactly as above.

Decomposition:
- Shared package arb_pkg:
  - NUM_REQ=4
  - IDX_W=2
  - typedef arb_state_t enum {IDLE, GRANT}
  - typedef arb_idx_t logic[IDX_W-1:0]
- One sub-module, rr_pick. It is purely combinational:
  - Inputs: req[3:0], last_idx.
  - Outputs: any_req, win_idx.
  - Reused by the top for both the IDLE pick and the GRANT handoff.

Test Plan:
- Reset, then req=4'b1111. Drop the current winner's req one cycle after each grant. Required: {x1,x0}=00, then 01, then 10, then 11, with grant_new pulsing each time and grant_valid held at 1 throughout.
- Only req[2] held for 20 cycles with MAX_HOLD=8. Required: {x1,x0}=10 and grant_valid=1 for all 20 cycles; grant_new is a single pulse on the first cycle only.
- req[0] and req[3] both held continuously with MAX_HOLD=8. Required: index 00 for 8 cycles, then 11 for 8 cycles, then 00 again; grant_new pulses at each switch; grant_valid never drops.
- Grant held on index 01, then req forced to 0. Required: grant_valid=0 on the next edge, {x1,x0} holds 01, grant_new=0. A subsequent req=4'b0010 produces a grant of 01 one cycle later, with a grant_new pulse.
- Mid-grant on index 10, pulse rst_n low between clock edges. Required: grant_valid=0 and {x1,x0}=00 immediately, without a clock edge. After release with req=4'b1100, the first grant is 10, because the search starts from index 0.
- Build with ARB_LOCK_EN, req=4'b0011, lock=1 for 20 cycles. Required: grant stays on 00 for all 20 cycles. When lock is dropped with hold_cnt saturated, the grant rotates to 01 on the next edge.
